muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter N, default 32: operand and HI/LO register width; legal range N >= 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 Start  input  1  request strobe; sampled on a rising edge.
REQ-005 Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
REQ-006 A  input  N  multiplicand, dividend, or MTHI/MTLO source.
REQ-007 B  input  N  multiplier or divisor.
REQ-008 Busy  output  1  high while an iterative operation is in flight.
REQ-009 Done  output  1  one-cycle pulse when HI/LO hold a new MULT/DIV result.
REQ-010 DivZero  output  1  high with Done when the completed operation divided by zero; otherwise low.
REQ-011 Hi  output  N  HI register (product upper half / remainder).
REQ-012 Lo  output  N  LO register (product lower half / quotient).

Function
REQ-013 States SHALL be IDLE, RUN, FIX; a request is accepted only when Start=1 at an edge where state is IDLE.
REQ-014 Start while Busy=1 SHALL be ignored, with no effect on state, operands or HI/LO.
REQ-015 Accepted MULT/MULTU/DIV/DIVU: the accept edge (edge 0) latches A, B, Op and sign info and moves the state to RUN with the iteration counter at N-1.
REQ-016 RUN SHALL perform exactly one radix-2 step per edge for N edges (edges 1..N), then move to FIX.
REQ-017 Multiply: shift-add on operand magnitudes, producing a 2N-bit unsigned product.
REQ-018 Divide: restoring shift-subtract on operand magnitudes, producing an N-bit quotient and an N-bit remainder.
REQ-019 FIX (edge N+1): apply sign correction, write Hi/Lo, return to IDLE, and drive Done=1 for exactly the following cycle.
REQ-020 Busy=1 from after edge 0 through the cycle before edge N+1; Busy=0 in the Done cycle; total latency from accept to Done is N+1 cycles.
REQ-021 Start in the Done cycle SHALL be accepted (back-to-back issue, no bubble).
REQ-022 MULT: if the operand signs differ, the product is the 2N-bit two's-complement negation; {Hi,Lo} = product.
REQ-023 MULTU: unsigned; {Hi,Lo} = A*B.
REQ-024 DIV: Lo = quotient truncated toward zero, negated if the operand signs differ; Hi = remainder carrying the sign of A; all values wrap to N bits.
REQ-025 DIV with A = most-negative and B = -1: Lo = most-negative, Hi = 0, DivZero=0, no other flag.
REQ-026 DIVU: unsigned; Lo = A/B, Hi = A%B.
REQ-027 B=0 on DIV or DIVU: Lo = all-ones, Hi = A, DivZero=1 during the Done cycle; latency is unchanged.
REQ-028 MTHI/MTLO: write A to Hi or Lo at the accept edge; the other register is unchanged; no Busy, no Done.
REQ-029 No-op codes: no state change, no Done.
REQ-030 Hi/Lo SHALL hold their value during RUN/FIX and change only at the FIX edge, an MTHI/MTLO edge, or reset.
REQ-031 DivZero SHALL be low in every cycle except a Done cycle of a zero-divisor division.

Reset
REQ-032 While reset_n=0, regardless of clk: state=IDLE, counter=0, Busy=0, Done=0, DivZero=0, Hi=0, Lo=0.
REQ-033 Reset asserted during RUN or FIX SHALL abort the operation; no Done follows deassertion.
REQ-034 The first edge after reset_n rises SHALL be able to accept a Start.

Verification (N=32)
REQ-035 MULT A=FFFFFFFF, B=00000002 -> Done 33 cycles after accept; Hi=FFFFFFFF, Lo=FFFFFFFE.
REQ-036 MULTU A=FFFFFFFF, B=00000002 -> Hi=00000001, Lo=FFFFFFFE; then DIV A=FFFFFFF9 (-7), B=00000002 issued in the Done cycle -> Lo=FFFFFFFD, Hi=FFFFFFFF.
REQ-037 DIVU A=00000007, B=0 -> Lo=FFFFFFFF, Hi=00000007, DivZero=1 for one cycle only; DIV A=80000000, B=FFFFFFFF -> Lo=80000000, Hi=0, DivZero=0.
REQ-038 MTHI A=12345678, then MTLO A=9ABCDEF0 -> Hi=12345678, Lo=9ABCDEF0 after the respective edges; Busy and Done stay 0.
REQ-039 Start MULTU at cycle 5 of a running DIVU -> ignored; only the DIVU result appears, with a single Done.
REQ-040 reset_n pulsed low mid-RUN -> Busy, Hi and Lo go to 0 immediately (asynchronously); no Done follows.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers: one radix-2 step per
// cycle, signed operands handled as magnitudes with a final sign fix-up.
module muldiv_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         Start,
  input  logic [2:0]   Op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         Busy,
  output logic         Done,
  output logic         DivZero,
  output logic [N-1:0] Hi,
  output logic [N-1:0] Lo
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  logic           accept, start_iter;

  logic [2*N-1:0] work;
  logic [N-1:0]   operand, a_raw;
  logic           is_div, neg_res, neg_rem, div0;

  logic           op_sa, op_sb;
  logic [N-1:0]   op_mag_a, op_mag_b;
  logic [N:0]     mul_sum, div_shift, div_diff;
  logic [2*N-1:0] mul_step, div_step, prod;
  logic [N-1:0]   res_hi, res_lo;

  function automatic logic [N-1:0] neg_n(input logic [N-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  assign Busy = (state != IDLE);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    start_iter = 1'b0;
    case (state)
      IDLE: if (Start) begin
        accept = 1'b1;
        if (!Op[2]) begin
          start_iter = 1'b1;
          state_next = RUN;
        end
      end
      RUN:     if (cnt == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand conditioning: MULT/DIV (Op[0]=0) are signed, the U variants are not.
  always_comb begin
    op_sa    = ~Op[0] & A[N-1];
    op_sb    = ~Op[0] & B[N-1];
    op_mag_a = neg_n(A, op_sa);
    op_mag_b = neg_n(B, op_sb);
  end

  // One radix-2 step: shift-add keeps {product_hi, multiplier}, restoring
  // divide keeps {remainder, dividend/quotient} in the same register.
  always_comb begin
    mul_sum   = {1'b0, work[2*N-1:N]} + {1'b0, (work[0] ? operand : '0)};
    mul_step  = {mul_sum, work[N-1:1]};
    div_shift = {work[2*N-1:N], work[N-1]};
    div_diff  = div_shift - {1'b0, operand};
    div_step  = div_diff[N] ? {div_shift[N-1:0], work[N-2:0], 1'b0}
                            : {div_diff[N-1:0],  work[N-2:0], 1'b1};
  end

  always_comb begin
    prod   = neg_2n(work, neg_res);
    res_hi = prod[2*N-1:N];
    res_lo = prod[N-1:0];
    if (is_div) begin
      if (div0) begin
        res_hi = a_raw;
        res_lo = '1;
      end else begin
        res_hi = neg_n(work[2*N-1:N], neg_rem);
        res_lo = neg_n(work[N-1:0], neg_res);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
      Hi      <= '0;
      Lo      <= '0;
    end else begin
      state   <= state_next;
      Done    <= 1'b0;
      DivZero <= 1'b0;
      if (start_iter)
        cnt <= CNT_LAST;
      else if (state == RUN && cnt != '0)
        cnt <= cnt - 1'b1;
      if (accept && Op == 3'b100) Hi <= A;
      if (accept && Op == 3'b101) Lo <= A;
      if (state == FIX) begin
        Done    <= 1'b1;
        DivZero <= div0;
        Hi      <= res_hi;
        Lo      <= res_lo;
      end
    end
  end

  // Datapath registers carry no reset; they are always loaded on accept.
  always_ff @(posedge clk) begin
    if (start_iter) begin
      is_div  <= Op[1];
      neg_res <= op_sa ^ op_sb;
      neg_rem <= op_sa;
      div0    <= Op[1] && (B == '0);
      a_raw   <= A;
      operand <= Op[1] ? op_mag_b : op_mag_a;
      work    <= {{N{1'b0}}, (Op[1] ? op_mag_a : op_mag_b)};
    end else if (state == RUN) begin
      work <= is_div ? div_step : mul_step;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (N=32): scoreboard of expected HI/LO/DivZero
// and Done timing, checked whenever the DUT pulses Done.
module tb_muldiv_unit;
  localparam int N = 32;

  logic          clk, reset_n, Start;
  logic [2:0]    Op;
  logic [N-1:0]  A, B;
  logic          Busy, Done, DivZero;
  logic [N-1:0]  Hi, Lo;

  muldiv_unit #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_seen = 0;
  int          exp_dones = 0;
  logic [31:0] sh_hi = '0, sh_lo = '0, prev_hi = '0, prev_lo = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    int          q, r;
    e.dz = 1'b0;
    e.cyc = 0;
    e.hi = '0;
    e.lo = '0;
    case (op)
      3'd0: begin
        p = 64'(longint'(int'(a)) * longint'(int'(b)));
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      3'd1: begin
        p = {32'b0, a} * {32'b0, b};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      3'd2: begin
        if (b == 0) begin
          e.lo = '1; e.hi = a; e.dz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = a; e.hi = '0;
        end else begin
          q = int'(a) / int'(b);
          r = int'(a) % int'(b);
          e.lo = q;
          e.hi = r;
        end
      end
      default: begin
        if (b == 0) begin
          e.lo = '1; e.hi = a; e.dz = 1'b1;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    Start = 1'b1; Op = op; A = a; B = b;
    if (push && op < 3'd4) begin
      e = model(op, a, b);
      e.cyc = cyc + N + 2;
      sb.push_back(e);
      prev_hi = sh_hi; prev_lo = sh_lo;
      sh_hi = e.hi; sh_lo = e.lo;
      exp_dones++;
    end
    if (push && op == 3'd4) sh_hi = a;
    if (push && op == 3'd5) sh_lo = a;
    step(1);
    Start = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (Done !== 1'b1 && k < 100) begin
      step(1);
      k++;
    end
    if (Done !== 1'b1) chk("done_timeout", 64'd0, 64'd1);
  endtask

  // Scoreboard consumer: every Done must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && Done === 1'b1) begin
      done_seen++;
      if (sb.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("res_hi", 64'(Hi), 64'(e.hi));
        chk("res_lo", 64'(Lo), 64'(e.lo));
        chk("res_divzero", 64'(DivZero), 64'(e.dz));
        chk("done_latency", 64'(cyc), 64'(e.cyc));
      end
    end
    if (DivZero === 1'b1 && Done !== 1'b1) chk("divzero_without_done", 64'd1, 64'd0);
  end

  logic [2:0]  t_op [7];
  logic [31:0] t_a  [7];
  logic [31:0] t_b  [7];

  initial begin
    t_op = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd2};
    t_a  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0007,
             32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h8000_0000};
    t_b  = '{32'h0000_0005, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
             32'h0000_0000, 32'h0000_0010, 32'h0000_0003};

    reset_n = 1'b0; Start = 1'b0; Op = 3'b110; A = '0; B = '0;
    step(3);
    chk("reset_busy", 64'(Busy), 64'd0);
    chk("reset_done", 64'(Done), 64'd0);
    chk("reset_divzero", 64'(DivZero), 64'd0);
    chk("reset_hi", 64'(Hi), 64'd0);
    chk("reset_lo", 64'(Lo), 64'd0);
    reset_n = 1'b1;

    // First edge after reset accepts; Hi/Lo hold through RUN.
    issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
    chk("busy_after_accept", 64'(Busy), 64'd1);
    step(10);
    chk("hold_hi_run", 64'(Hi), 64'(prev_hi));
    chk("hold_lo_run", 64'(Lo), 64'(prev_lo));
    wait_done();
    chk("busy_in_done", 64'(Busy), 64'd0);

    // Back-to-back issues in the Done cycle.
    issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
    wait_done();
    issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
    wait_done();
    issue(3'd3, 32'h0000_0007, 32'h0000_0000, 1'b1);
    wait_done();
    step(1);
    chk("divzero_one_cycle", 64'(DivZero), 64'd0);
    chk("done_one_cycle", 64'(Done), 64'd0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done();

    for (int i = 0; i < 7; i++) begin
      issue(t_op[i], t_a[i], t_b[i], 1'b1);
      wait_done();
    end
    step(2);

    // Moves to HI/LO and a no-op.
    issue(3'd4, 32'h1234_5678, 32'h0, 1'b1);
    chk("mthi_hi", 64'(Hi), 64'(sh_hi));
    chk("mthi_lo_kept", 64'(Lo), 64'(sh_lo));
    chk("mthi_busy", 64'(Busy), 64'd0);
    issue(3'd5, 32'h9ABC_DEF0, 32'h0, 1'b1);
    chk("mtlo_lo", 64'(Lo), 64'h9ABC_DEF0);
    chk("mtlo_hi_kept", 64'(Hi), 64'h1234_5678);
    chk("mtlo_done", 64'(Done), 64'd0);
    issue(3'd6, 32'hDEAD_BEEF, 32'h1, 1'b1);
    chk("noop_busy", 64'(Busy), 64'd0);
    chk("noop_hi", 64'(Hi), 64'(sh_hi));
    chk("noop_lo", 64'(Lo), 64'(sh_lo));

    // Start while busy is ignored.
    issue(3'd3, 32'h0000_1000, 32'h0000_0007, 1'b1);
    step(3);
    issue(3'd1, 32'h0000_0003, 32'h0000_0004, 1'b0);
    chk("busy_ignored_start", 64'(Busy), 64'd1);
    wait_done();
    step(40);
    chk("ignored_hi", 64'(Hi), 64'(sh_hi));
    chk("ignored_lo", 64'(Lo), 64'(sh_lo));

    // Asynchronous reset mid-RUN aborts the operation.
    issue(3'd0, 32'h0000_0011, 32'h0000_0022, 1'b1);
    step(10);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_hi", 64'(Hi), 64'd0);
    chk("abort_lo", 64'(Lo), 64'd0);
    sb.delete();
    exp_dones--;
    sh_hi = '0; sh_lo = '0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(40);
    issue(3'd1, 32'h0000_0003, 32'h0000_0004, 1'b1);
    wait_done();
    step(3);

    chk("done_count", 64'(done_seen), 64'(exp_dones));
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
